// File: rtl/video_pkg.sv
// Shared definitions for the video test-pattern generator: pattern codes,
// FSM encoding and colour constants (24-bit pixels packed as R[23:16] B[15:8] G[7:0]).
package video_pkg;

  localparam int COORD_W = 16;

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_RAMP  = 2'd1,
    PAT_CHECK = 2'd2,
    PAT_SOLID = 2'd3
  } pattern_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  localparam logic [23:0] RGB_WHITE = 24'hFFFFFF;
  localparam logic [23:0] RGB_BLACK = 24'h000000;
  localparam logic [23:0] RGB_GRAY  = 24'h808080;

  // Bar order left to right; byte layout is R, B, G.
  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    logic [23:0] c;
    c = RGB_BLACK;
    case (idx)
      3'd0: c = 24'hFFFFFF; // white
      3'd1: c = 24'hFF00FF; // yellow
      3'd2: c = 24'h00FFFF; // cyan
      3'd3: c = 24'h0000FF; // green
      3'd4: c = 24'hFFFF00; // magenta
      3'd5: c = 24'hFF0000; // red
      3'd6: c = 24'h00FF00; // blue
      default: c = RGB_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/video_pattern_gen_if.sv
// AXI4-Stream video bundle as seen from the generator (master) and the sink (slave).
interface video_pattern_gen_if #(
  parameter int TDATA_WIDTH = 96
) ();
  logic                   tvalid;
  logic                   tready;
  logic                   tuser;
  logic                   tlast;
  logic [TDATA_WIDTH-1:0] tdata;

  modport master (output tvalid, tdata, tuser, tlast, input tready);
  modport slave  (input tvalid, tdata, tuser, tlast, output tready);
endinterface

// File: rtl/video_pattern_pixel.sv
// Colour of one pixel for a given pattern and (x, y) position; pure combinational.
module video_pattern_pixel
  import video_pkg::*;
#(
  parameter int H_ACTIVE       = 1920,
  parameter int BITS_PER_PIXEL = 24
) (
  input  pattern_e                  pattern,
  input  logic [COORD_W-1:0]        px,
  input  logic [COORD_W-1:0]        py,
  output logic [BITS_PER_PIXEL-1:0] pixel
);

  localparam int BAR_W = H_ACTIVE / 8;

  logic [2:0]  bar;
  logic [23:0] rgb;
  logic        unused_py;

  // Only bit 5 of y matters (checker squares are 32 lines tall).
  assign unused_py = ^{py[COORD_W-1:6], py[4:0]};

  always_comb begin
    bar = '0;
    for (int i = 1; i < 8; i++)
      if (px >= COORD_W'(i * BAR_W)) bar = 3'(i);
  end

  always_comb begin
    rgb = RGB_BLACK;
    case (pattern)
      PAT_BARS:  rgb = bar_colour(bar);
      PAT_RAMP:  rgb = {3{px[7:0]}};
      PAT_CHECK: rgb = (px[5] ^ py[5]) ? RGB_WHITE : RGB_BLACK;
      PAT_SOLID: rgb = RGB_GRAY;
      default:   rgb = RGB_BLACK;
    endcase
  end

  assign pixel = BITS_PER_PIXEL'(rgb);

endmodule

// File: rtl/video_pattern_gen.sv
// AXI4-Stream test-pattern source: one frame per run request, all stream outputs
// registered; the beat at (x_q, y_q) is what currently sits on the output.
module video_pattern_gen
  import video_pkg::*;
#(
  parameter int SAMPLES_PER_CLOCK = 4,
  parameter int BITS_PER_PIXEL    = 24,
  parameter int TDATA_WIDTH       = SAMPLES_PER_CLOCK * BITS_PER_PIXEL,
  parameter int H_ACTIVE          = 1920,
  parameter int V_ACTIVE          = 1080
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   enable,
  input  logic [1:0]             pattern_sel,
  output logic                   m_axis_video_tvalid,
  output logic [TDATA_WIDTH-1:0] m_axis_video_tdata,
  output logic                   m_axis_video_tuser,
  output logic                   m_axis_video_tlast,
  input  logic                   m_axis_video_tready,
  output logic [15:0]            frame_count
);

  localparam int BEATS = H_ACTIVE / SAMPLES_PER_CLOCK;
  localparam int XW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int YW    = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(BEATS - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

  state_e                 state_q, state_d;
  pattern_e               pat_q, pat_d;
  logic [XW-1:0]          x_q, x_d;
  logic [YW-1:0]          y_q, y_d;
  logic [15:0]            frame_count_q, frame_count_d;
  logic                   tvalid_q, tvalid_d;
  logic                   tuser_q, tuser_d;
  logic                   tlast_q, tlast_d;
  logic [TDATA_WIDTH-1:0] tdata_q, tdata_d;

  // Position/pattern of the beat about to be loaded into the output register.
  logic                   load;
  logic [XW-1:0]          ld_x;
  logic [YW-1:0]          ld_y;
  pattern_e               ld_pat;
  logic                   xfer;
  logic [SAMPLES_PER_CLOCK-1:0][BITS_PER_PIXEL-1:0] pix;

  for (genvar k = 0; k < SAMPLES_PER_CLOCK; k++) begin : g_pix
    logic [COORD_W-1:0] px;
    assign px = COORD_W'(ld_x) * COORD_W'(SAMPLES_PER_CLOCK) + COORD_W'(k);
    video_pattern_pixel #(
      .H_ACTIVE      (H_ACTIVE),
      .BITS_PER_PIXEL(BITS_PER_PIXEL)
    ) u_pix (
      .pattern(ld_pat),
      .px     (px),
      .py     (COORD_W'(ld_y)),
      .pixel  (pix[k])
    );
  end

  assign xfer = tvalid_q & m_axis_video_tready;

  always_comb begin
    state_d       = state_q;
    pat_d         = pat_q;
    x_d           = x_q;
    y_d           = y_q;
    frame_count_d = frame_count_q;
    tvalid_d      = tvalid_q;
    tuser_d       = tuser_q;
    tlast_d       = tlast_q;
    tdata_d       = tdata_q;
    load          = 1'b0;
    ld_x          = '0;
    ld_y          = '0;
    ld_pat        = pat_q;

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_ACTIVE;
          load    = 1'b1;
          ld_pat  = pattern_e'(pattern_sel);
        end
      end
      ST_ACTIVE: begin
        if (xfer) begin
          if (x_q != X_LAST) begin
            load = 1'b1;
            ld_x = x_q + XW'(1);
            ld_y = y_q;
          end else if (y_q != Y_LAST) begin
            load = 1'b1;
            ld_y = y_q + YW'(1);
          end else begin
            frame_count_d = frame_count_q + 16'd1;
            // Run request is only honoured at frame boundaries.
            if (enable) begin
              load   = 1'b1;
              ld_pat = pattern_e'(pattern_sel);
            end else begin
              state_d  = ST_IDLE;
              x_d      = '0;
              y_d      = '0;
              tvalid_d = 1'b0;
              tuser_d  = 1'b0;
              tlast_d  = 1'b0;
              tdata_d  = '0;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      x_d      = ld_x;
      y_d      = ld_y;
      pat_d    = ld_pat;
      tvalid_d = 1'b1;
      tuser_d  = (ld_x == '0) && (ld_y == '0);
      tlast_d  = (ld_x == X_LAST);
      tdata_d  = TDATA_WIDTH'(pix);
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q       <= ST_IDLE;
      pat_q         <= PAT_BARS;
      x_q           <= '0;
      y_q           <= '0;
      frame_count_q <= '0;
      tvalid_q      <= 1'b0;
      tuser_q       <= 1'b0;
      tlast_q       <= 1'b0;
      tdata_q       <= '0;
    end else begin
      state_q       <= state_d;
      pat_q         <= pat_d;
      x_q           <= x_d;
      y_q           <= y_d;
      frame_count_q <= frame_count_d;
      tvalid_q      <= tvalid_d;
      tuser_q       <= tuser_d;
      tlast_q       <= tlast_d;
      tdata_q       <= tdata_d;
    end
  end

  assign m_axis_video_tvalid = tvalid_q;
  assign m_axis_video_tdata  = tdata_q;
  assign m_axis_video_tuser  = tuser_q;
  assign m_axis_video_tlast  = tlast_q;
  assign frame_count         = frame_count_q;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Directed bench for video_pattern_gen at 64x4, 4 samples per beat.
module tb_video_pattern_gen;

  localparam int SPC = 4;
  localparam int BPP = 24;
  localparam int TDW = SPC * BPP;
  localparam int H   = 64;
  localparam int V   = 4;
  localparam int BPL = H / SPC;
  localparam int BPF = BPL * V;

  typedef struct {
    int          beat;
    int          k;
    logic [23:0] exp;
  } vec_t;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        enable;
  logic [1:0]  pattern_sel;
  logic [15:0] frame_count;

  video_pattern_gen_if #(.TDATA_WIDTH(TDW)) vif ();

  video_pattern_gen #(
    .SAMPLES_PER_CLOCK(SPC),
    .BITS_PER_PIXEL   (BPP),
    .TDATA_WIDTH      (TDW),
    .H_ACTIVE         (H),
    .V_ACTIVE         (V)
  ) dut (
    .aclk               (aclk),
    .aresetn            (aresetn),
    .enable             (enable),
    .pattern_sel        (pattern_sel),
    .m_axis_video_tvalid(vif.tvalid),
    .m_axis_video_tdata (vif.tdata),
    .m_axis_video_tuser (vif.tuser),
    .m_axis_video_tlast (vif.tlast),
    .m_axis_video_tready(vif.tready),
    .frame_count        (frame_count)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;

  logic [TDW-1:0] cap_d[$];
  logic [1:0]     cap_f[$];
  logic [TDW-1:0] ref_d[$];
  logic [1:0]     ref_f[$];
  logic           stall_prev = 1'b0;
  logic [TDW-1:0] prev_d;
  logic [1:0]     prev_f;
  vec_t           vecs[$];

  task automatic chk(input string name, input logic [TDW-1:0] act, input logic [TDW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] model_px(input int pat, input int px, input int py);
    logic [7:0] g;
    logic [23:0] c;
    g = px[7:0];
    c = 24'h0;
    case (pat)
      0: case (px / (H / 8))
           0: c = 24'hFFFFFF; 1: c = 24'hFF00FF; 2: c = 24'h00FFFF; 3: c = 24'h0000FF;
           4: c = 24'hFFFF00; 5: c = 24'hFF0000; 6: c = 24'h00FF00; default: c = 24'h000000;
         endcase
      1: c = {g, g, g};
      2: c = (((px >> 5) ^ (py >> 5)) & 1) != 0 ? 24'hFFFFFF : 24'h000000;
      default: c = 24'h808080;
    endcase
    return c;
  endfunction

  function automatic logic [TDW-1:0] model_beat(input int pat, input int idx);
    logic [TDW-1:0] r;
    int x, y;
    x = idx % BPL;
    y = (idx / BPL) % V;
    r = '0;
    for (int k = 0; k < SPC; k++) r[k*BPP +: BPP] = model_px(pat, x * SPC + k, y);
    return r;
  endfunction

  // One clock: sample at the falling edge, return just after the rising edge.
  task automatic cycle();
    @(negedge aclk);
    if (stall_prev) begin
      chk("stall_valid", TDW'(vif.tvalid), TDW'(1));
      chk("stall_data", vif.tdata, prev_d);
      chk("stall_flags", TDW'({vif.tuser, vif.tlast}), TDW'(prev_f));
    end
    if (vif.tvalid && vif.tready) begin
      cap_d.push_back(vif.tdata);
      cap_f.push_back({vif.tuser, vif.tlast});
    end
    stall_prev = vif.tvalid && !vif.tready;
    prev_d = vif.tdata;
    prev_f = {vif.tuser, vif.tlast};
    @(posedge aclk);
    #1;
  endtask

  task automatic run_until(input int n);
    int b;
    b = 0;
    while (cap_d.size() < n && b < 3000) begin
      cycle();
      b++;
    end
    if (cap_d.size() < n) chk("timeout", TDW'(cap_d.size()), TDW'(n));
  endtask

  task automatic clear_cap();
    cap_d.delete();
    cap_f.delete();
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    stall_prev = 1'b0;
    clear_cap();
  endtask

  initial begin
    int b;
    logic [TDW-1:0] d;
    aresetn = 1'b0;
    enable = 1'b0;
    pattern_sel = 2'd0;
    vif.tready = 1'b0;

    vecs.push_back(vec_t'{0, 0, 24'hFFFFFF});
    vecs.push_back(vec_t'{0, 3, 24'hFFFFFF});
    vecs.push_back(vec_t'{2, 0, 24'hFF00FF});
    vecs.push_back(vec_t'{2, 3, 24'hFF00FF});
    vecs.push_back(vec_t'{4, 1, 24'h00FFFF});
    vecs.push_back(vec_t'{6, 0, 24'h0000FF});
    vecs.push_back(vec_t'{8, 2, 24'hFFFF00});
    vecs.push_back(vec_t'{10, 0, 24'hFF0000});
    vecs.push_back(vec_t'{13, 3, 24'h00FF00});
    vecs.push_back(vec_t'{15, 3, 24'h000000});
    vecs.push_back(vec_t'{18, 0, 24'hFF00FF});
    vecs.push_back(vec_t'{63, 3, 24'h000000});
    vecs.push_back(vec_t'{67, 0, 24'h0C0C0C});
    vecs.push_back(vec_t'{67, 1, 24'h0D0D0D});
    vecs.push_back(vec_t'{67, 2, 24'h0E0E0E});
    vecs.push_back(vec_t'{67, 3, 24'h0F0F0F});
    vecs.push_back(vec_t'{79, 3, 24'h3F3F3F});
    vecs.push_back(vec_t'{80, 0, 24'h000000});
    vecs.push_back(vec_t'{85, 2, 24'h161616});
    vecs.push_back(vec_t'{133, 2, 24'h808080});
    vecs.push_back(vec_t'{191, 3, 24'h808080});

    // Reset state
    do_reset();
    chk("rst_tvalid", TDW'(vif.tvalid), '0);
    chk("rst_tuser", TDW'(vif.tuser), '0);
    chk("rst_tlast", TDW'(vif.tlast), '0);
    chk("rst_tdata", vif.tdata, '0);
    chk("rst_frame_count", TDW'(frame_count), '0);

    // Three back-to-back frames, pattern switched mid-frame each time
    aresetn = 1'b1;
    enable = 1'b1;
    vif.tready = 1'b1;
    run_until(10);
    pattern_sel = 2'd1;
    run_until(63);
    chk("fc_before_end", TDW'(frame_count), TDW'(0));
    run_until(64);
    chk("fc_after_frame", TDW'(frame_count), TDW'(1));
    run_until(74);
    pattern_sel = 2'd3;
    run_until(138);
    enable = 1'b0;
    run_until(192);
    chk("idle_tvalid", TDW'(vif.tvalid), '0);
    chk("fc_three", TDW'(frame_count), TDW'(3));
    repeat (4) cycle();
    chk("beat_total", TDW'(cap_d.size()), TDW'(192));

    foreach (vecs[i]) begin
      d = cap_d[vecs[i].beat];
      chk($sformatf("vec%0d_b%0d_k%0d", i, vecs[i].beat, vecs[i].k),
          TDW'(d[vecs[i].k*BPP +: BPP]), TDW'(vecs[i].exp));
    end
    for (int i = 0; i < cap_d.size(); i++) begin
      chk($sformatf("p1_data_%0d", i), cap_d[i], model_beat(i < 64 ? 0 : (i < 128 ? 1 : 3), i));
      chk($sformatf("p1_flags_%0d", i), TDW'(cap_f[i]),
          TDW'({(i % BPF) == 0, (i % BPL) == BPL - 1}));
    end
    for (int i = 64; i < 128; i++) begin
      ref_d.push_back(cap_d[i]);
      ref_f.push_back(cap_f[i]);
    end

    // Random stalls against the zero-stall ramp frame
    do_reset();
    aresetn = 1'b1;
    pattern_sel = 2'd1;
    enable = 1'b1;
    b = 0;
    while (cap_d.size() < 64 && b < 2000) begin
      vif.tready = $urandom_range(0, 1) == 1;
      if (cap_d.size() >= 5) enable = 1'b0;
      cycle();
      b++;
    end
    vif.tready = 1'b1;
    repeat (5) cycle();
    chk("stall_beat_total", TDW'(cap_d.size()), TDW'(64));
    chk("stall_idle", TDW'(vif.tvalid), '0);
    chk("stall_fc", TDW'(frame_count), TDW'(1));
    for (int i = 0; i < 64 && i < cap_d.size(); i++) begin
      chk($sformatf("stall_data_%0d", i), cap_d[i], ref_d[i]);
      chk($sformatf("stall_flags_%0d", i), TDW'(cap_f[i]), TDW'(ref_f[i]));
    end

    // Mid-frame pattern change and stop request, then restart
    do_reset();
    aresetn = 1'b1;
    pattern_sel = 2'd0;
    enable = 1'b1;
    run_until(20);
    pattern_sel = 2'd2;
    run_until(30);
    enable = 1'b0;
    run_until(64);
    chk("stop_tvalid", TDW'(vif.tvalid), '0);
    chk("stop_fc", TDW'(frame_count), TDW'(1));
    repeat (3) cycle();
    chk("stop_beats", TDW'(cap_d.size()), TDW'(64));
    chk("stop_bars_b40", cap_d[40], model_beat(0, 40));
    chk("stop_bars_b21", cap_d[21], model_beat(0, 21));
    clear_cap();
    enable = 1'b1;
    run_until(64);
    chk("chk_b0", cap_d[0], {SPC{24'h000000}});
    chk("chk_b8", cap_d[8], {SPC{24'hFFFFFF}});
    chk("chk_b0_tuser", TDW'(cap_f[0]), TDW'(2'b10));
    for (int i = 0; i < 64; i++)
      chk($sformatf("chk_data_%0d", i), cap_d[i], model_beat(2, i));

    // Reset in the middle of a frame
    clear_cap();
    pattern_sel = 2'd0;
    run_until(40);
    aresetn = 1'b0;
    @(posedge aclk);
    #1;
    chk("mrst_tvalid", TDW'(vif.tvalid), '0);
    chk("mrst_tuser", TDW'(vif.tuser), '0);
    chk("mrst_tlast", TDW'(vif.tlast), '0);
    chk("mrst_tdata", vif.tdata, '0);
    chk("mrst_fc", TDW'(frame_count), '0);
    stall_prev = 1'b0;
    clear_cap();
    aresetn = 1'b1;
    run_until(1);
    chk("mrst_first_flags", TDW'(cap_f[0]), TDW'(2'b10));
    chk("mrst_first_data", cap_d[0], {SPC{24'hFFFFFF}});
    chk("mrst_first_fc", TDW'(frame_count), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
